roberto_uc: RTL and testbench
=============================

# roberto_uc

Control unit for the three-sensor ultrasonic ranging datapath. It sequences one measurement cycle: reset the datapath, trigger all three sensors, wait out the one-tick measurement window, then stream a 12-character ASCII frame over the serial transmitter. The frame is three sensors × (hundreds, tens, units, '#'). It sits directly upstream of the datapath: it drives every `zera_*`, `cont_*`, `medir` and `partida_tx` strobe, and consumes `pronto_seg`, `pronto_serial`, `Q_2` and `Q_3`.

## Interface
Parameters:
- `LAST_SENSOR`, default 2'd2: final value of the sensor index `Q_2`.
- `LAST_CHAR`, default 2'd3: final value of the character index `Q_3`, which is the '#' slot.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces state `inicial`.
- `ligar`  in  1  run enable, level; sampled in `inicial` and `fim`.
- `pronto_seg`  in  1  end-of-window pulse from the tick counter.
- `pronto_serial`  in  1  one-cycle pulse: the transmitter has finished a character.
- `Q_2`  in  2  current sensor index from the datapath.
- `Q_3`  in  2  current character index from the datapath.
- `zera_sensor`, `zera_serial`, `zera_seg`, `zera_2`, `zera_3`  out  1 each  synchronous clears to the datapath.
- `cont_seg`, `cont_2`, `cont_3`  out  1 each  counter enables.
- `medir`  out  1  one-cycle measure strobe to all three sensor interfaces.
- `partida_tx`  out  1  one-cycle transmit start.
- `db_estado`  out  4  current state code.

## Operation
- Moore FSM; every output is decoded from the state only.
- While `reset`=0, all outputs are 0 and `db_estado`=4'h0.
- States (code: outputs asserted → transition):
  - `inicial` (0): none → `preparacao` if `ligar`.
  - `preparacao` (1): all five `zera_*` → `mede`.
  - `mede` (2): `medir`, `zera_seg` → `espera`.
  - `espera` (3): `cont_seg` → `transmite` on `pronto_seg`, else stay.
  - `transmite` (4): `partida_tx` → `espera_tx`.
  - `espera_tx` (5): none. On `pronto_serial`: go to `proximo_sensor` if `Q_3`==`LAST_CHAR`, else `proximo_char`. Without `pronto_serial`, stay.
  - `proximo_char` (6): `cont_3` → `transmite`.
  - `proximo_sensor` (7): `zera_3`, `cont_2` → `fim` if `Q_2`==`LAST_SENSOR` (value sampled before the increment), else `transmite`.
  - `fim` (8): `zera_2` → `mede` if `ligar`, else `inicial`.
- Unused codes 9–15 → `inicial` on the next edge.
- `ligar` falling mid-frame does not abort the frame. It is checked only in `fim`.
- `pronto_seg` arriving outside `espera` is ignored. `pronto_serial` arriving outside `espera_tx` is ignored.
- `Q_2`/`Q_3` are trusted; the block keeps no shadow copy of either index.

## Timing
- `ligar` sampled high in `inicial` at edge k: `preparacao` at k+1, `medir` high during cycle k+2 (exactly one cycle).
- Measurement window = `pronto_seg` latency of the tick counter, counted from the cycle after `mede`.
- Per character: `partida_tx` 1 cycle, then `espera_tx` until `pronto_serial`, then 1 cycle in `proximo_char` or `proximo_sensor`.
- Frame = 12 `partida_tx` pulses, in order `Q_2`=0..2, each with `Q_3`=0..3.
- Indices change one edge after `cont_*`. By the time the FSM re-enters `transmite`, the datapath mux has settled.
- Back-to-back frames: `fim` → `mede` with no `preparacao`. Only the tick counter and index counters are re-cleared.

## Structure
- Shared package `roberto_pkg`: 4-bit state code localparams (`INICIAL` … `FIM`), `LAST_SENSOR`, `LAST_CHAR`.
- The datapath top and the bench import the same package.
- Single module: a state register plus next-state and output decode. No sub-module is warranted.

## Test plan
- Reset: hold `reset`=0 with `ligar`=1 → all outputs 0, `db_estado`=0. Release → `medir` pulses exactly once, 2 cycles later.
- Full frame: `ligar`=1; model `pronto_seg` after 50 cycles and `pronto_serial` 10 cycles after each `partida_tx`; model `Q_2`/`Q_3` counters → exactly 12 `partida_tx` pulses, one `cont_2` per sensor, `fim` reached once.
- Stall: withhold `pronto_serial` for 1000 cycles → FSM stays in state 5, `partida_tx` not re-asserted.
- `ligar` dropped mid-frame at character 5 → remaining 7 characters still sent, then `inicial`, `medir` silent.
- Continuous run: `ligar` held → second `medir` in the cycle after `fim`, no `zera_serial` between frames.
- Async reset asserted in `espera_tx` mid-frame → state 0 immediately (before the next edge), outputs 0. Restart sends a complete new frame.

Source files
------------

// File: rtl/roberto_pkg.sv
// Shared definitions for the ultrasonic ranging control unit and its datapath.
package roberto_pkg;

  // 4-bit state codes, also exported on db_estado
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    MEDE           = 4'h2,
    ESPERA         = 4'h3,
    TRANSMITE      = 4'h4,
    ESPERA_TX      = 4'h5,
    PROXIMO_CHAR   = 4'h6,
    PROXIMO_SENSOR = 4'h7,
    FIM            = 4'h8
  } estado_t;

  // Final sensor index (three sensors) and final character index ('#' slot)
  localparam logic [1:0] LAST_SENSOR = 2'd2;
  localparam logic [1:0] LAST_CHAR   = 2'd3;

endpackage

// File: rtl/roberto_uc.sv
// Control unit: sequences one measurement cycle and streams the 12-character
// frame (3 sensors x hundreds/tens/units/'#') through the serial transmitter.
module roberto_uc #(
  parameter logic [1:0] LAST_SENSOR = roberto_pkg::LAST_SENSOR,
  parameter logic [1:0] LAST_CHAR   = roberto_pkg::LAST_CHAR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_seg,
  input  logic       pronto_serial,
  input  logic [1:0] Q_2,
  input  logic [1:0] Q_3,
  output logic       zera_sensor,
  output logic       zera_serial,
  output logic       zera_seg,
  output logic       zera_2,
  output logic       zera_3,
  output logic       cont_seg,
  output logic       cont_2,
  output logic       cont_3,
  output logic       medir,
  output logic       partida_tx,
  output logic [3:0] db_estado
);
  import roberto_pkg::*;

  estado_t estado, estado_next;

  // State register, asynchronous active-low reset to inicial
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_next;
  end

  // Next-state logic; indices are trusted from the datapath, no shadow copy
  always_comb begin
    estado_next = estado;
    unique case (estado)
      INICIAL:        estado_next = ligar ? PREPARACAO : INICIAL;
      PREPARACAO:     estado_next = MEDE;
      MEDE:           estado_next = ESPERA;
      ESPERA:         estado_next = pronto_seg ? TRANSMITE : ESPERA;
      TRANSMITE:      estado_next = ESPERA_TX;
      ESPERA_TX: begin
        if (pronto_serial)
          estado_next = (Q_3 == LAST_CHAR) ? PROXIMO_SENSOR : PROXIMO_CHAR;
      end
      PROXIMO_CHAR:   estado_next = TRANSMITE;
      // Q_2 here is the value before this cycle's cont_2 takes effect
      PROXIMO_SENSOR: estado_next = (Q_2 == LAST_SENSOR) ? FIM : TRANSMITE;
      // Back-to-back frames skip preparacao
      FIM:            estado_next = ligar ? MEDE : INICIAL;
      default:        estado_next = INICIAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    zera_sensor = 1'b0;
    zera_serial = 1'b0;
    zera_seg    = 1'b0;
    zera_2      = 1'b0;
    zera_3      = 1'b0;
    cont_seg    = 1'b0;
    cont_2      = 1'b0;
    cont_3      = 1'b0;
    medir       = 1'b0;
    partida_tx  = 1'b0;
    unique case (estado)
      PREPARACAO: begin
        zera_sensor = 1'b1;
        zera_serial = 1'b1;
        zera_seg    = 1'b1;
        zera_2      = 1'b1;
        zera_3      = 1'b1;
      end
      MEDE: begin
        medir    = 1'b1;
        zera_seg = 1'b1;
      end
      ESPERA:       cont_seg   = 1'b1;
      TRANSMITE:    partida_tx = 1'b1;
      PROXIMO_CHAR: cont_3     = 1'b1;
      PROXIMO_SENSOR: begin
        zera_3 = 1'b1;
        cont_2 = 1'b1;
      end
      FIM:          zera_2     = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_roberto_uc.sv
// Bench for roberto_uc: a behavioural datapath (index counters, tick counter,
// transmitter) with randomized latencies and stray pulses; the expected frame
// is the fixed order sensor 0..2 x char 0..3.
module tb_roberto_uc;
  import roberto_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ligar = 1'b0;
  logic       pronto_seg = 1'b0;
  logic       pronto_serial = 1'b0;
  logic [1:0] Q_2 = '0;
  logic [1:0] Q_3 = '0;
  logic       zera_sensor, zera_serial, zera_seg, zera_2, zera_3;
  logic       cont_seg, cont_2, cont_3, medir, partida_tx;
  logic [3:0] db_estado;

  roberto_uc #(
    .LAST_SENSOR(roberto_pkg::LAST_SENSOR),
    .LAST_CHAR  (roberto_pkg::LAST_CHAR)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar),
    .pronto_seg(pronto_seg), .pronto_serial(pronto_serial),
    .Q_2(Q_2), .Q_3(Q_3),
    .zera_sensor(zera_sensor), .zera_serial(zera_serial), .zera_seg(zera_seg),
    .zera_2(zera_2), .zera_3(zera_3),
    .cont_seg(cont_seg), .cont_2(cont_2), .cont_3(cont_3),
    .medir(medir), .partida_tx(partida_tx), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  // environment state
  int unsigned seg_win = 50;
  int unsigned seg_cnt = 0;
  bit          seg_active = 0;
  int unsigned tx_rem = 0;
  bit          stall = 0;

  // observations
  logic [3:0]  frame_log[$];
  int unsigned frame_cont2 = 0;
  int unsigned frame_fim = 0;
  int unsigned medir_cnt = 0;
  int unsigned partida_cnt = 0;
  int unsigned zera_serial_cnt = 0;

  function automatic logic [14:0] all_out();
    return {zera_sensor, zera_serial, zera_seg, zera_2, zera_3,
            cont_seg, cont_2, cont_3, medir, partida_tx, db_estado};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs sampled before the edge drive the datapath model
  task automatic tick();
    logic p_zs, p_cs, p_z2, p_c2, p_z3, p_c3, p_tx, p_ps;
    @(negedge clock);
    p_zs = zera_seg; p_cs = cont_seg; p_z2 = zera_2; p_c2 = cont_2;
    p_z3 = zera_3;   p_c3 = cont_3;   p_tx = partida_tx; p_ps = pronto_seg;
    @(posedge clock);
    #1;
    if (p_z2) Q_2 = '0; else if (p_c2) Q_2 = Q_2 + 2'd1;
    if (p_z3) Q_3 = '0; else if (p_c3) Q_3 = Q_3 + 2'd1;
    // tick counter
    if (p_ps && seg_active) seg_active = 0;
    if (p_zs) begin seg_cnt = 0; seg_active = 1; end
    else if (p_cs) seg_cnt++;
    if (seg_active) pronto_seg = (seg_cnt >= seg_win);
    else            pronto_seg = ($urandom_range(0, 3) == 0);
    // transmitter
    if (p_tx) begin
      tx_rem = $urandom_range(1, 12);
      pronto_serial = 1'b0;
    end else if (tx_rem > 0) begin
      tx_rem--;
      pronto_serial = (tx_rem == 0) && !stall;
    end else begin
      pronto_serial = !stall && ($urandom_range(0, 3) == 0);
    end
    // monitors
    if (medir) begin
      medir_cnt++;
      frame_log.delete();
      frame_cont2 = 0;
      frame_fim = 0;
    end
    if (partida_tx) begin
      partida_cnt++;
      frame_log.push_back({Q_2, Q_3});
    end
    if (cont_2) frame_cont2++;
    if (db_estado == 4'h8) frame_fim++;
    if (zera_serial) zera_serial_cnt++;
  endtask

  task automatic wait_for(input logic [3:0] code, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (db_estado !== code && n < budget) begin tick(); n++; end
    chk(tag, db_estado, code);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_chars"}, frame_log.size(), 12);
    chk({tag, "_cont2"}, frame_cont2, 3);
    chk({tag, "_fim"}, frame_fim, 1);
    for (int i = 0; i < frame_log.size(); i++) begin
      logic [3:0] exp_pair;
      exp_pair = {2'(i / 4), 2'(i % 4)};
      chk($sformatf("%s_pair%0d", tag, i), frame_log[i], exp_pair);
    end
  endtask

  task automatic env_clear();
    Q_2 = '0; Q_3 = '0; seg_cnt = 0; seg_active = 0; tx_rem = 0; stall = 0;
    pronto_seg = 1'b0; pronto_serial = 1'b0;
  endtask

  initial begin
    int unsigned n;
    int unsigned m0, p0, zs0;

    // reset held with ligar high
    ligar = 1'b1;
    seg_win = $urandom_range(5, 60);
    repeat (3) tick();
    chk("reset_outputs", all_out(), '0);
    env_clear();
    reset = 1'b1;
    tick();
    chk("after_release_state", db_estado, 4'h1);
    chk("preparacao_zeras", {zera_sensor, zera_serial, zera_seg, zera_2, zera_3}, 5'h1f);
    chk("medir_not_early", medir, 1'b0);
    tick();
    chk("medir_k2", medir, 1'b1);
    chk("mede_state", db_estado, 4'h2);
    tick();
    chk("medir_one_cycle", medir, 1'b0);
    chk("medir_count", medir_cnt, 1);

    // full frame, continuous run into second frame
    wait_for(4'h8, 5000, "frame1_reach_fim");
    check_frame("frame1");
    zs0 = zera_serial_cnt;
    m0 = medir_cnt;
    tick();
    chk("b2b_medir", medir, 1'b1);
    chk("b2b_state", db_estado, 4'h2);
    chk("b2b_no_zera_serial", zera_serial_cnt, zs0);
    chk("b2b_medir_count", medir_cnt, m0 + 1);

    // drop ligar after the 5th character of frame 2
    seg_win = $urandom_range(1, 40);
    n = 0;
    while (frame_log.size() < 5 && n < 3000) begin tick(); n++; end
    chk("frame2_reach_char5", frame_log.size(), 5);
    ligar = 1'b0;
    wait_for(4'h0, 5000, "frame2_back_inicial");
    check_frame("frame2");
    m0 = medir_cnt;
    repeat (30) tick();
    chk("idle_medir_silent", medir_cnt, m0);
    chk("idle_state", db_estado, 4'h0);

    // stall in espera_tx
    ligar = 1'b1;
    seg_win = $urandom_range(1, 20);
    wait_for(4'h5, 3000, "stall_reach_espera_tx");
    stall = 1;
    p0 = partida_cnt;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (db_estado !== 4'h5) n++;
    end
    chk("stall_state_held", n, 0);
    chk("stall_no_partida", partida_cnt, p0);
    chk("stall_db_estado", db_estado, 4'h5);

    // asynchronous reset mid-cycle while in espera_tx
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", all_out(), '0);
    env_clear();
    tick();
    chk("reset_hold_outputs", all_out(), '0);
    reset = 1'b1;
    seg_win = $urandom_range(1, 60);
    wait_for(4'h8, 5000, "restart_reach_fim");
    check_frame("restart");
    ligar = 1'b0;
    tick();
    chk("restart_end_inicial", db_estado, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
